// File: rtl/cgen_lut_bank.sv
// cgen_lut_bank: N_OUT runtime-loadable truth tables over N_IN shared inputs, evaluated in a 2-stage valid/ready pipeline.
// Defining CGEN_READBACK_EN adds a registered table readback port (rb_addr/rb_data/rb_valid).
module cgen_lut_bank #(
    parameter int  N_IN  = 3,
    parameter int  N_OUT = 12,
    parameter int  CNT_W = 16,
    localparam int TW    = 1 << N_IN,
    localparam int AW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [TW-1:0]    cfg_data,
    input  logic             cfg_commit,
    input  logic             cfg_req,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] f,
    output logic [CNT_W-1:0] eval_cnt,
    output logic [1:0]       state_o
`ifdef CGEN_READBACK_EN
    ,
    input  logic [AW-1:0]    rb_addr,
    output logic [TW-1:0]    rb_data,
    output logic             rb_valid
`endif
);

    typedef enum logic [1:0] {
        S_UNCFG = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_CFG   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tbl_q [N_OUT];
    logic [N_OUT-1:0] mask_q, mask_d;
    logic             cfg_err_q, cfg_err_d;
    logic             s1_valid_q, s1_valid_d;
    logic [N_IN-1:0]  s1_x_q, s1_x_d;
    logic             s2_valid_q, s2_valid_d;
    logic [N_OUT-1:0] f_q, f_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             addr_ok, wr_en, s1_en, s2_en, in_fire, out_fire;
    logic [N_OUT-1:0] lut_f;

    assign cfg_ready = (state_q == S_UNCFG) || (state_q == S_CFG);
    assign addr_ok   = 32'(cfg_addr) < N_OUT;
    assign wr_en     = cfg_ready && cfg_we && addr_ok;

    // A stage may load when it is empty or its content moves on this cycle.
    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = (state_q == S_RUN) && s1_en;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cfg_err_d = 1'b0;
        unique case (state_q)
            S_UNCFG, S_CFG: begin
                if (cfg_we) begin
                    if (addr_ok) mask_d = mask_q | (N_OUT'(1) << cfg_addr);
                    else         cfg_err_d = 1'b1;
                end
                // Commit sees the mask including a write in the same cycle.
                if (cfg_commit) begin
                    if (&mask_d) state_d   = S_RUN;
                    else         cfg_err_d = 1'b1;
                end
            end
            S_RUN:   if (cfg_req) state_d = S_DRAIN;
            S_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = S_CFG;
            default: state_d = S_UNCFG;
        endcase
    end

    always_comb begin
        lut_f = '0;
        for (int k = 0; k < N_OUT; k++) lut_f[k] = tbl_q[k][s1_x_q];
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s2_valid_d = s2_valid_q;
        f_d        = f_q;
        cnt_d      = cnt_q;
        if (s1_en) begin
            s1_valid_d = in_fire;
            if (in_fire) s1_x_d = x;
        end
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) f_d = lut_f;
        end
        if (out_fire && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: the table array is reset because a freshly reset bank must read as all-zero functions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_UNCFG;
            mask_q     <= '0;
            cfg_err_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s2_valid_q <= 1'b0;
            f_q        <= '0;
            cnt_q      <= '0;
            for (int k = 0; k < N_OUT; k++) tbl_q[k] <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            mask_q     <= mask_d;
            cfg_err_q  <= cfg_err_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s2_valid_q <= s2_valid_d;
            f_q        <= f_d;
            cnt_q      <= cnt_d;
            for (int k = 0; k < N_OUT; k++) begin
                if (wr_en && (32'(cfg_addr) == k)) tbl_q[k] <= cfg_data;
            end
        end
    end

    assign cfg_err   = cfg_err_q;
    assign out_valid = s2_valid_q;
    assign f         = f_q;
    assign eval_cnt  = cnt_q;
    assign state_o   = state_q;

`ifdef CGEN_READBACK_EN
    logic [TW-1:0] rb_sel, rb_data_q;
    logic          rb_ok, rb_valid_q;

    assign rb_ok = 32'(rb_addr) < N_OUT;

    always_comb begin
        rb_sel = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (32'(rb_addr) == k) rb_sel = tbl_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_data_q  <= rb_sel;
            rb_valid_q <= rb_ok;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`endif

endmodule

// File: tb/tb_cgen_lut_bank.sv
// Bench for cgen_lut_bank: vector table for single lookups, scoreboard queue for streamed and drained traffic.
module tb_cgen_lut_bank;

    localparam int N_IN  = 3;
    localparam int N_OUT = 12;
    localparam int CNT_W = 16;
    localparam int TW    = 8;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we, cfg_commit, cfg_req;
    logic [AW-1:0]    cfg_addr;
    logic [TW-1:0]    cfg_data;
    logic             cfg_ready, cfg_err;
    logic             in_valid, in_ready;
    logic [N_IN-1:0]  x;
    logic             out_valid, out_ready;
    logic [N_OUT-1:0] f;
    logic [CNT_W-1:0] eval_cnt;
    logic [1:0]       state_o;

    cgen_lut_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_req    (cfg_req),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .f          (f),
        .eval_cnt   (eval_cnt),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_IN-1:0] x;
        logic            f4;
        logic            f5;
    } vec_t;

    vec_t             vecs [8];
    int               errors = 0;
    int               checks = 0;
    logic [N_OUT-1:0] sb_q [$];
    logic [N_IN-1:0]  send_q [$];
    logic [TW-1:0]    mtab [N_OUT];
    int               exp_cnt = 0;
    int               rx_cnt = 0;
    int               ready_mode = 0;
    int               cyc_no = 0;
    logic             stalled = 1'b0;
    logic [N_OUT-1:0] held_f = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_OUT-1:0] model_f(input logic [N_IN-1:0] xv);
        logic [N_OUT-1:0] r;
        r = '0;
        for (int k = 0; k < N_OUT; k++) r[k] = mtab[k][xv];
        return r;
    endfunction

    task automatic cfg_write(input logic [AW-1:0] a, input logic [TW-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        if (32'(a) < N_OUT) mtab[a] = d;
        step();
        cfg_we = 1'b0;
        check("cfg_err_after_write", cfg_err, 32'(a) >= N_OUT);
    endtask

    // One scoreboard cycle: drive from send_q, account handshakes, advance one clock.
    task automatic cycle();
        logic [N_OUT-1:0] e;
        in_valid  = (send_q.size() != 0);
        x         = in_valid ? send_q[0] : '0;
        out_ready = (ready_mode == 0) ? 1'b1 : ((cyc_no % 2) == 0);
        #1;
        if (stalled) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_f_held", f, held_f);
        end
        if (out_valid && out_ready) begin
            rx_cnt++;
            if (exp_cnt < 65535) exp_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got f=0x%0h with empty scoreboard", f);
            end else begin
                e = sb_q.pop_front();
                check("scoreboard_f", f, e);
            end
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(model_f(x));
            void'(send_q.pop_front());
        end
        stalled = out_valid && !out_ready;
        held_f  = f;
        cyc_no++;
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_stream(input int budget, output int used);
        int c = 0;
        stalled = 1'b0;
        cyc_no  = 0;
        while ((send_q.size() != 0 || sb_q.size() != 0) && c < budget) begin
            cycle();
            c++;
        end
        used = c;
        check("stream_completed", (send_q.size() == 0) && (sb_q.size() == 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        int w;
        // 0x66 -> f4 at bits 1,2,5,6; 0xAA -> f5 at odd bits
        vecs[0] = '{3'd0, 1'b0, 1'b0};
        vecs[1] = '{3'd1, 1'b1, 1'b1};
        vecs[2] = '{3'd2, 1'b1, 1'b0};
        vecs[3] = '{3'd3, 1'b0, 1'b1};
        vecs[4] = '{3'd4, 1'b0, 1'b0};
        vecs[5] = '{3'd5, 1'b1, 1'b1};
        vecs[6] = '{3'd6, 1'b1, 1'b0};
        vecs[7] = '{3'd7, 1'b0, 1'b1};
        for (int k = 0; k < N_OUT; k++) mtab[k] = '0;

        rst_n = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_req = 1'b0;
        cfg_addr = '0; cfg_data = '0; in_valid = 1'b0; x = '0; out_ready = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_state", state_o, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_f", f, 0);
        check("rst_eval_cnt", eval_cnt, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 0);

        for (int a = 0; a < 11; a++)
            cfg_write(4'(a), (a == 4) ? 8'h66 : (a == 5) ? 8'hAA : 8'h00);

        cfg_commit = 1'b1; in_valid = 1'b1;
        step();
        cfg_commit = 1'b0;
        check("partial_commit_err", cfg_err, 1);
        check("partial_commit_state", state_o, 0);
        check("partial_commit_in_ready", in_ready, 0);
        step();
        check("err_pulse_one_cycle", cfg_err, 0);
        in_valid = 1'b0;

        cfg_write(4'd12, 8'hFF);
        step();
        check("bad_addr_err_clears", cfg_err, 0);
        cfg_write(4'd15, 8'hFF);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        check("mask_unchanged_commit_err", cfg_err, 1);
        check("mask_unchanged_state", state_o, 0);

        cfg_req = 1'b1;
        step();
        cfg_req = 1'b0;
        check("uncfg_ignores_req", state_o, 0);

        cfg_we = 1'b1; cfg_addr = 4'd11; cfg_data = 8'h00; cfg_commit = 1'b1;
        mtab[11] = 8'h00;
        step();
        cfg_we = 1'b0; cfg_commit = 1'b0;
        check("write_commit_state", state_o, 1);
        check("write_commit_err", cfg_err, 0);
        check("run_cfg_ready", cfg_ready, 0);

        cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 8'hFF;
        step();
        cfg_we = 1'b0;

        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; x = vecs[i].x; out_ready = 1'b1;
            #1;
            check("vec_in_ready", in_ready, 1);
            step();
            in_valid = 1'b0;
            check("vec_latency_1", out_valid, 0);
            step();
            check("vec_latency_2", out_valid, 1);
            check("vec_f4", f[4], vecs[i].f4);
            check("vec_f5", f[5], vecs[i].f5);
            check("vec_f_others", f & ~12'h030, 0);
            exp_cnt++;
            step();
            check("vec_consumed", out_valid, 0);
        end
        check("eval_cnt_after_vectors", eval_cnt, exp_cnt);

        ready_mode = 0;
        for (int i = 0; i < 8; i++) send_q.push_back(3'(i));
        run_stream(40, used);
        check("full_throughput_cycles", used, 10);

        ready_mode = 1;
        rx_cnt = 0;
        for (int i = 0; i < 8; i++) send_q.push_back(3'(i));
        run_stream(60, used);
        check("toggle_stream_results", rx_cnt, 8);
        check("eval_cnt_after_streams", eval_cnt, exp_cnt);

        ready_mode = 0;
        stalled = 1'b0;
        send_q.push_back(3'd1);
        send_q.push_back(3'd2);
        cycle();
        cycle();
        cfg_req = 1'b1;
        #1;
        check("pre_drain_in_ready", in_ready, 1);
        check("pre_drain_state", state_o, 1);
        cycle();
        cfg_req = 1'b0;
        check("drain_state", state_o, 2);
        check("drain_in_ready", in_ready, 0);
        check("drain_cfg_ready", cfg_ready, 0);
        w = 0;
        while (state_o != 2'd3 && w < 10) begin
            cycle();
            w++;
        end
        check("drain_reaches_cfg", state_o, 3);
        check("drain_results_delivered", sb_q.size(), 0);
        check("cfg_cfg_ready", cfg_ready, 1);
        check("eval_cnt_after_drain", eval_cnt, exp_cnt);

        cfg_write(4'd5, 8'h55);
        cfg_commit = 1'b1; cfg_req = 1'b1;
        step();
        cfg_commit = 1'b0; cfg_req = 1'b0;
        check("recommit_state", state_o, 1);
        check("recommit_err", cfg_err, 0);

        in_valid = 1'b1; x = 3'd0; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        check("new_table_valid", out_valid, 1);
        check("new_table_f", f, 12'h020);
        step();
        check("hold_valid", out_valid, 1);
        check("hold_f", f, 12'h020);

        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_f", f, 0);
        check("async_rst_eval_cnt", eval_cnt, 0);
        check("async_rst_state", state_o, 0);
        check("async_rst_in_ready", in_ready, 0);
        for (int k = 0; k < N_OUT; k++) mtab[k] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 0);
        check("post_rst_out_valid", out_valid, 0);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0; in_valid = 1'b0;
        check("post_rst_commit_err", cfg_err, 1);
        check("post_rst_state", state_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
